led_display_sched: RTL
======================

# led_display_sched

Front-panel LED display scheduler that shares the 8 board LEDs between the idle two-eye cylon pattern and up to three status requesters. Accepts one-cycle request pulses, arbitrates by fixed priority with preemption, holds each granted pattern (optionally blinking) for a fixed number of display ticks, and inserts a blank gap before returning to the cylon or the next requester. Sits between the cylon generator output and the LED pins. It also drives the cylon rate input from a configuration register.

## Interface
- MXPRE, 21: tick prescaler width; tick period is 2^MXPRE clocks (~52 ms at 40 MHz). Benches use 4.
- HOLD_TICKS, 4: display ticks per grant; legal range 1..7; 3-bit hold counter.
- clock  in  1  40 MHz system clock
- reset  in  1  synchronous, active-high reset
- cylon_q  in  8  idle pattern from the cylon generator
- rate_cfg  in  2  requested cylon speed
- cylon_rate  out  2  registered copy of rate_cfg, fed to the cylon generator
- req  in  3  request pulses; req[0] is the highest priority
- pat0, pat1, pat2  in  8 each  pattern for each requester; sampled on grant
- blink  in  3  per-requester blink enable; sampled on grant
- ack  out  3  one-cycle grant pulse, one-hot
- busy  out  1  high in SHOW or GAP
- owner  out  2  requester currently displayed: 0..2 in SHOW, 3 otherwise
- leds  out  8  registered LED drive

## Operation
- Prescaler:
  - Increments by 1 every non-reset clock.
  - tick is a one-cycle pulse when the prescaler is all ones; wraps to 0.
- Pending register pend[2:0]:
  - req[i] = 1 on an edge sets pend[i].
  - A grant to i clears pend[i].
  - If req[i] and the grant to i occur in the same cycle, set wins and the request is re-queued. A held-high req therefore causes back-to-back service.
- Arbitration: winner is the lowest index with pend set.
- States:
  - IDLE:
    - leds <= cylon_q every clock.
    - If pend != 0: grant the winner and go to SHOW.
  - SHOW:
    - leds <= latched pattern. If latched blink = 1, leds <= latched pattern when phase = 1, else 8'h00.
    - phase toggles on each tick and is set to 1 on every grant.
    - hold decrements on tick. A tick with hold == 1 goes to GAP.
  - GAP:
    - leds <= 8'h00.
    - On the next tick: if pend != 0, grant the winner and go to SHOW; else go to IDLE.
- Grant actions, all on the same edge:
  - ack[i] = 1 for one cycle; owner <= i; pend[i] cleared.
  - Latch pat_i and blink[i]; hold <= HOLD_TICKS; phase <= 1.
- Preemption:
  - In SHOW, if a pend bit with index < owner is set, re-grant immediately to the new winner, with no GAP.
  - The preempted requester is dropped, not re-queued.
  - Equal or lower priority requests wait.
- Ticks are free-running, so the first hold period is partial. Display time per grant is more than (HOLD_TICKS-1) and at most HOLD_TICKS tick periods.
- cylon_rate <= rate_cfg every clock.

## Timing
- Reset values: state IDLE; pend 0; ack 0; busy 0; owner 3; leds 8'h00; cylon_rate 0; prescaler 0; hold 0; phase 1.
- First cylon pattern appears on leds one clock after reset deasserts.
- Request latency, for req high on edge N in IDLE:
  - pend set after edge N.
  - After edge N+1: ack high and leds = pattern.
  - Total latency from request edge to LEDs is 2 clocks.
- SHOW to GAP: leds go to 0 on the edge that samples the final tick. GAP lasts exactly one tick period.
- IDLE return: leds follow cylon_q from the edge that samples the GAP-ending tick.
- Preemption latency is 2 clocks from req to the new pattern; the old owner's display ends immediately.
- Simultaneous requests: the lowest index wins; others stay pending and are served in index order after each GAP.
- Reset mid-SHOW or mid-GAP: the next clock returns to IDLE reset values; pending requests are lost.
- ack is never high for two consecutive cycles except for a preemption grant immediately after a grant.

## Test plan
- Reset, then idle with cylon_q = 8'h81 → one clock later leds = 8'h81, owner = 3, busy = 0, ack = 0.
- MXPRE = 4, HOLD_TICKS = 4, req[1] pulse with pat1 = 8'hA5, blink = 0:
  - 2 clocks later ack = 3'b010, leds = 8'hA5, owner = 1.
  - leds = 8'hA5 held until the 4th tick (49 to 64 clocks, depending on prescaler phase).
  - Then leds = 8'h00 for exactly 16 clocks.
  - Then leds = cylon_q.
- req[2] with blink[2] = 1 and pat2 = 8'hFF → leds alternate 8'hFF / 8'h00 on each tick, starting with 8'hFF, for the hold duration.
- Same-cycle req = 3'b101:
  - req 0 is served first, then GAP, then req 2 with ack = 3'b100.
  - No IDLE cylon appears in between.
- Preemption and no-preemption:
  - During SHOW of requester 2, a req[0] pulse → leds switch to pat0 2 clocks later, ack = 3'b001, owner = 0. Requester 2 is never re-shown.
  - During SHOW of requester 0, a req[2] pulse → requester 2 is shown only after requester 0's GAP.
- Assert reset in the middle of SHOW with pend = 3'b100 → after one clock all outputs are at reset values; with no new req, leds follow cylon_q and requester 2 is not served.

Source files
------------

// File: rtl/led_display_sched_if.sv
// Requester-side bundle of the LED display scheduler: request pulses, per-requester
// patterns and blink enables going in; grant pulse, busy and current owner coming back.
interface led_display_sched_if;
  logic [2:0] req;
  logic [7:0] pat0;
  logic [7:0] pat1;
  logic [7:0] pat2;
  logic [2:0] blink;
  logic [2:0] ack;
  logic       busy;
  logic [1:0] owner;

  modport master (
    output req, pat0, pat1, pat2, blink,
    input  ack, busy, owner
  );

  modport slave (
    input  req, pat0, pat1, pat2, blink,
    output ack, busy, owner
  );
endinterface

// File: rtl/led_display_sched.sv
// Shares the 8 front-panel LEDs between the idle cylon pattern and three prioritised
// status requesters: fixed-priority grant with preemption, tick-timed hold, blank gap.
module led_display_sched #(
  parameter int MXPRE      = 21,
  parameter int HOLD_TICKS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                cylon_q,
  input  logic [1:0]                rate_cfg,
  output logic [1:0]                cylon_rate,
  output logic [7:0]                leds,
  led_display_sched_if.slave        bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [MXPRE-1:0]   pre_q, pre_d;
  logic [2:0]         pend_q, pend_d;
  logic [2:0]         ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [1:0]         owner_q, owner_d;
  logic [7:0]         leds_q, leds_d;
  logic [1:0]         rate_q, rate_d;
  logic [2:0]         hold_q, hold_d;
  logic               phase_q, phase_d;
  logic [7:0]         pat_q, pat_d;
  logic               blink_q, blink_d;

  logic               tick;
  logic               any_pend;
  logic [1:0]         win_idx;
  logic [7:0]         win_pat;
  logic               win_blink;
  logic               do_grant;

  always_comb begin
    pre_d     = pre_q + MXPRE'(1);
    tick      = &pre_q;
    any_pend  = |pend_q;
    win_idx   = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
    case (win_idx)
      2'd0:    win_pat = bus.pat0;
      2'd1:    win_pat = bus.pat1;
      default: win_pat = bus.pat2;
    endcase
    win_blink = bus.blink[win_idx];

    state_d  = state_q;
    hold_d   = hold_q;
    phase_d  = phase_q;
    pat_d    = pat_q;
    blink_d  = blink_q;
    owner_d  = owner_q;
    leds_d   = leds_q;
    do_grant = 1'b0;

    case (state_q)
      S_IDLE: begin
        leds_d   = cylon_q;
        do_grant = any_pend;
      end
      S_SHOW: begin
        // Only strictly higher priority (lower index) may cut a display short.
        if (any_pend && (win_idx < owner_q)) begin
          do_grant = 1'b1;
        end else begin
          if (tick) begin
            phase_d = ~phase_q;
            hold_d  = hold_q - 3'd1;
            if (hold_q == 3'd1) begin
              state_d = S_GAP;
              owner_d = 2'd3;
            end
          end
          leds_d = ((state_d == S_GAP) || (blink_q && !phase_d)) ? 8'h00 : pat_q;
        end
      end
      S_GAP: begin
        leds_d = 8'h00;
        if (tick) begin
          if (any_pend) begin
            do_grant = 1'b1;
          end else begin
            state_d = S_IDLE;
            leds_d  = cylon_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = 2'd3;
        leds_d  = 8'h00;
      end
    endcase

    ack_d = 3'b000;
    if (do_grant) begin
      state_d        = S_SHOW;
      ack_d[win_idx] = 1'b1;
      owner_d        = win_idx;
      pat_d          = win_pat;
      blink_d        = win_blink;
      hold_d         = 3'(HOLD_TICKS);
      phase_d        = 1'b1;
      leds_d         = win_pat;
    end

    // A request arriving on the grant edge re-queues: set beats clear.
    pend_d = (pend_q & ~ack_d) | bus.req;
    busy_d = (state_d != S_IDLE);
    rate_d = rate_cfg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      pend_q  <= 3'b000;
      ack_q   <= 3'b000;
      busy_q  <= 1'b0;
      owner_q <= 2'd3;
      leds_q  <= 8'h00;
      rate_q  <= 2'd0;
      hold_q  <= 3'd0;
      phase_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      leds_q  <= leds_d;
      rate_q  <= rate_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
    end
    pat_q   <= pat_d;
    blink_q <= blink_d;
  end

  assign bus.ack    = ack_q;
  assign bus.busy   = busy_q;
  assign bus.owner  = owner_q;
  assign leds       = leds_q;
  assign cylon_rate = rate_q;

endmodule
